// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: opcode classes, operations,
// state encodings and the decoded-instruction bundle.
package fetch_sequencer_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int PC_WIDTH   = 8;

    localparam logic [3:0] CLS_RAM = 4'h4;
    localparam logic [3:0] CLS_ROM = 4'h3;
    localparam logic [3:0] CLS_REG = 4'h9;
    localparam logic [3:0] CLS_PC  = 4'h7;

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;

    localparam logic [DATA_WIDTH-1:0] HALT_OPCODE = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    typedef struct packed {
        logic is_write;
        logic is_read;
        logic is_jump;
        logic is_halt;
    } dec_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Opcode/operand broadcast bus plus the program ROM and RAM read-back paths.
interface fetch_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 8
);
    logic [PC_WIDTH-1:0]     rom_addr;
    logic                    rom_rd_en;
    logic [2*DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0]   opcode;
    logic [DATA_WIDTH-1:0]   operand;
    logic                    read_enable;
    logic                    write_enable;
    logic [DATA_WIDTH-1:0]   ram_read_data;

    modport master (
        output rom_addr, rom_rd_en, opcode, operand,
        output read_enable, write_enable,
        input  rom_data, ram_read_data
    );

    modport slave (
        input  rom_addr, rom_rd_en, opcode, operand,
        input  read_enable, write_enable,
        output rom_data, ram_read_data
    );
endinterface

// File: rtl/fetch_sequencer_instr_class_decode.sv
// Combinational opcode classifier; the ALU stage reuses it.
module instr_class_decode
    import fetch_sequencer_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] opcode,
    output dec_t                  dec
);

    logic [3:0] cls;
    logic [3:0] op;
    logic       wr_cls;
    logic       rd_cls;

    assign cls    = opcode[15:12];
    assign op     = opcode[11:8];
    assign wr_cls = (cls == CLS_RAM) || (cls == CLS_ROM) || (cls == CLS_REG);
    assign rd_cls = (cls == CLS_RAM) || (cls == CLS_REG);

    // HALT sits in class F, so the arms below never overlap.
    always_comb begin
        dec = '0;
        unique case (1'b1)
            opcode == HALT_OPCODE: dec.is_halt = 1'b1;
            cls == CLS_PC: begin
                dec.is_jump = 1'b1;
                dec.is_read = 1'b1;
            end
            wr_cls && op == OP_WRITE: dec.is_write = 1'b1;
            rd_cls && op == OP_READ:  dec.is_read  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequence stage: FETCH -> LATCH -> EXEC per instruction.
// Optional single-step mode via FETCH_STEP_EN (adds a step input).
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
`ifdef FETCH_STEP_EN
    input  logic                step,
`endif
    fetch_sequencer_if.master   bus,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted
);

    state_e state;
    state_e state_nxt;

    logic [PC_WIDTH-1:0]   pc_q;
    logic [DATA_WIDTH-1:0] opcode_q;
    logic [DATA_WIDTH-1:0] operand_q;
    logic                  halted_q;
    logic                  go;
    logic                  in_exec;
    dec_t                  dec;
    logic                  unused_hi;

    instr_class_decode u_dec (
        .opcode (opcode_q),
        .dec    (dec)
    );

`ifdef FETCH_STEP_EN
    assign go = run && step;
`else
    assign go = run;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (go) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_LATCH;
            S_LATCH: state_nxt = S_EXEC;
            S_EXEC: begin
                if (dec.is_halt) begin
                    state_nxt = S_HALT;
`ifdef FETCH_STEP_EN
                end else begin
                    state_nxt = S_IDLE;
                end
`else
                end else begin
                    state_nxt = run ? S_FETCH : S_IDLE;
                end
`endif
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_exec = (state == S_EXEC);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            if (state == S_LATCH) begin
                opcode_q  <= bus.rom_data[2*DATA_WIDTH-1:DATA_WIDTH];
                operand_q <= bus.rom_data[DATA_WIDTH-1:0];
            end
            // A halted program keeps pc pointing at the HALT word.
            if (in_exec) begin
                if (dec.is_halt) begin
                    halted_q <= 1'b1;
                end else if (dec.is_jump) begin
                    pc_q <= bus.ram_read_data[PC_WIDTH-1:0];
                end else begin
                    pc_q <= pc_q + 1'b1;
                end
            end
        end
    end

    assign unused_hi = ^bus.ram_read_data[DATA_WIDTH-1:PC_WIDTH];

    assign bus.rom_addr     = pc_q;
    assign bus.rom_rd_en    = (state == S_FETCH);
    assign bus.opcode       = opcode_q;
    assign bus.operand      = operand_q;
    assign bus.write_enable = in_exec && dec.is_write;
    assign bus.read_enable  = in_exec && dec.is_read;
    assign pc               = pc_q;
    assign halted           = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: instruction table plus reset/halt/run corners.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] word;
        logic [15:0] ram;
        logic        exp_we;
        logic        exp_re;
        logic [7:0]  exp_pc;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       run;
    logic [7:0] pc;
    logic       halted;
`ifdef FETCH_STEP_EN
    logic       step;
    int         exec_cnt;
    logic       counting;
`endif

    logic [31:0] rom [256];
    logic [31:0] rom_q;

    int checks;
    int errors;

    fetch_sequencer_if #(.DATA_WIDTH(16), .PC_WIDTH(8)) bus ();

    fetch_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
`ifdef FETCH_STEP_EN
        .step   (step),
`endif
        .bus    (bus),
        .pc     (pc),
        .halted (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rom_rd_en) rom_q <= rom[bus.rom_addr];
    end
    assign bus.rom_data = rom_q;

`ifdef FETCH_STEP_EN
    always @(negedge clk) begin
        if (counting && (bus.write_enable || bus.read_enable))
            exec_cnt <= exec_cnt + 1;
    end
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", {31'd0, bus.rom_rd_en}, 0);
        chk("rst_we", {31'd0, bus.write_enable}, 0);
        chk("rst_re", {31'd0, bus.read_enable}, 0);
        chk("rst_opcode", {16'd0, bus.opcode}, 0);
        chk("rst_operand", {16'd0, bus.operand}, 0);
        chk("rst_pc", {24'd0, pc}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        reset = 1'b0;
    endtask

    task automatic wait_fetch(input string name);
        int n;
        n = 0;
        while (!bus.rom_rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rom_rd_en) begin
            checks++;
            errors++;
            $display("FAIL %s: no rom_rd_en within 20 cycles", name);
        end
    endtask

    task automatic run_instr(input vec_t v);
        wait_fetch("fetch_timeout");
        chk("rom_addr", {24'd0, bus.rom_addr}, {24'd0, v.addr});
        bus.ram_read_data = v.ram;
        @(negedge clk);
        chk("latch_strobes",
            {30'd0, bus.write_enable, bus.read_enable}, 0);
        @(negedge clk);
        chk("opcode", {16'd0, bus.opcode}, {16'd0, v.word[31:16]});
        chk("operand", {16'd0, bus.operand}, {16'd0, v.word[15:0]});
        chk("we", {31'd0, bus.write_enable}, {31'd0, v.exp_we});
        chk("re", {31'd0, bus.read_enable}, {31'd0, v.exp_re});
        @(negedge clk);
        chk("next_pc", {24'd0, pc}, {24'd0, v.exp_pc});
    endtask

    vec_t vt [9];
    vec_t hv;
    int   busy;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        run    = 1'b0;
        bus.ram_read_data = '0;
        for (int i = 0; i < 256; i++) rom[i] = '0;
`ifdef FETCH_STEP_EN
        step     = 1'b1;
        exec_cnt = 0;
        counting = 1'b0;
`endif

        vt[0] = '{8'h00, 32'h4105_00AA, 16'h0000, 1'b1, 1'b0, 8'h01};
        vt[1] = '{8'h01, 32'h4200_0005, 16'h0000, 1'b0, 1'b1, 8'h02};
        vt[2] = '{8'h02, 32'h7000_0010, 16'h0040, 1'b0, 1'b1, 8'h40};
        vt[3] = '{8'h40, 32'h3100_1234, 16'h0000, 1'b1, 1'b0, 8'h41};
        vt[4] = '{8'h41, 32'h9200_0000, 16'h0000, 1'b0, 1'b1, 8'h42};
        vt[5] = '{8'h42, 32'h9100_BEEF, 16'h0000, 1'b1, 1'b0, 8'h43};
        vt[6] = '{8'h43, 32'h4300_0001, 16'h0000, 1'b0, 1'b0, 8'h44};
        vt[7] = '{8'h44, 32'h3200_0002, 16'hFF00, 1'b0, 1'b0, 8'h45};
        vt[8] = '{8'h45, 32'h7100_0003, 16'hAB45, 1'b0, 1'b1, 8'h45};

        foreach (vt[i]) rom[vt[i].addr] = vt[i].word;

        @(negedge clk);
        do_reset();
        run = 1'b1;
        foreach (vt[i]) run_instr(vt[i]);
        // self-jump keeps looping at the same address
        wait_fetch("selfjump_timeout");
        chk("selfjump_addr", {24'd0, bus.rom_addr}, 32'h45);

        // wrap FF -> 00, then HALT at 00
        do_reset();
        rom[8'h00] = 32'h7000_0000;
        rom[8'hFF] = 32'h0000_0000;
        run = 1'b1;
        hv = '{8'h00, 32'h7000_0000, 16'h00FF, 1'b0, 1'b1, 8'hFF};
        run_instr(hv);
        rom[8'h00] = 32'hFFFF_0000;
        hv = '{8'hFF, 32'h0000_0000, 16'h0000, 1'b0, 1'b0, 8'h00};
        run_instr(hv);
        wait_fetch("halt_fetch_timeout");
        chk("halt_addr", {24'd0, bus.rom_addr}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("halt_strobes",
            {30'd0, bus.write_enable, bus.read_enable}, 0);
        @(negedge clk);
        chk("halted", {31'd0, halted}, 1);
        busy = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rom_rd_en || bus.write_enable || bus.read_enable)
                busy++;
        end
        chk("halt_quiet", busy, 0);
        chk("halted_hold", {31'd0, halted}, 1);

        // reset during LATCH aborts the instruction
        do_reset();
        rom[8'h00] = 32'h4105_00AA;
        run = 1'b1;
        wait_fetch("abort_fetch_timeout");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rd_en", {31'd0, bus.rom_rd_en}, 0);
        chk("abort_opcode", {16'd0, bus.opcode}, 0);
        chk("abort_operand", {16'd0, bus.operand}, 0);
        chk("abort_pc", {24'd0, pc}, 0);
        chk("abort_strobes",
            {30'd0, bus.write_enable, bus.read_enable}, 0);
        reset = 1'b0;
        run   = 1'b0;

        // run dropped during FETCH: the instruction still completes
        @(negedge clk);
        run = 1'b1;
        wait_fetch("drop_fetch_timeout");
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drop_we", {31'd0, bus.write_enable}, 1);
        chk("drop_opcode", {16'd0, bus.opcode}, 32'h4105);
        @(negedge clk);
        chk("drop_pc", {24'd0, pc}, 1);
        busy = 0;
        repeat (6) begin
            if (bus.rom_rd_en) busy++;
            @(negedge clk);
        end
        chk("drop_idle", busy, 0);

`ifdef FETCH_STEP_EN
        do_reset();
        rom[8'h00] = 32'h4105_0001;
        rom[8'h01] = 32'h4105_0002;
        step     = 1'b0;
        run      = 1'b1;
        counting = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (10) @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (15) @(negedge clk);
        counting = 1'b0;
        chk("step_exec_cnt", exec_cnt, 2);
        chk("step_pc", {24'd0, pc}, 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
